// File: rtl/tag_search_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tag_search_ctrl_pkg
// Shared definitions for the sequential tag-search controller:
//   - FSM state encoding (IDLE / SCAN / DONE)
//   - default tag width, entry count and index width
// ---------------------------------------------------------------------------
package tag_search_ctrl_pkg;

   // Default geometry: 6-bit tags, 8 entries, 3-bit index
   localparam int TS_W  = 6;
   localparam int TS_N  = 8;
   localparam int TS_IW = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } ts_state_t;

endpackage : tag_search_ctrl_pkg

// File: rtl/tag_eq6.sv
// ---------------------------------------------------------------------------
// tag_eq6
// Gate-level 6-bit equality comparator: per-bit XOR, then a 6-input NOR
// (OR-reduce followed by inversion).
// Ports:
//   a    in  6  first operand (selected stored tag)
//   b    in  6  second operand (search key)
//   equ  out 1  1 when a == b
// ---------------------------------------------------------------------------
module tag_eq6 (
   input  logic [5:0] a,
   input  logic [5:0] b,
   output logic       equ
);

   logic [5:0] w_diff;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_bit
         xor u_xor (w_diff[gi], a[gi], b[gi]);
      end
   endgenerate

   nor u_nor (equ, w_diff[0], w_diff[1], w_diff[2],
                   w_diff[3], w_diff[4], w_diff[5]);

endmodule : tag_eq6

// File: rtl/tag_search_ctrl.sv
// ---------------------------------------------------------------------------
// tag_search_ctrl
// Sequential associative lookup over an N-entry tag store using a single
// shared tag_eq6 comparator. One entry is examined per cycle in ascending
// order, so the lowest valid matching index wins.
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   asynchronous active-high reset (clears store + FSM)
//   wr_en      in  1   tag store write strobe (legal in every state)
//   wr_idx     in  IW  entry written
//   wr_tag     in  W   tag value written
//   wr_vld     in  1   valid bit written (0 invalidates)
//   req_valid  in  1   search request
//   req_ready  out 1   high only in IDLE
//   req_key    in  W   search key, captured on accept
//   rsp_valid  out 1   result available (DONE)
//   rsp_ready  in  1   consumer takes result
//   rsp_hit    out 1   match found (0 outside DONE)
//   rsp_idx    out IW  lowest matching index (0 on miss / outside DONE)
//   busy       out 1   high in SCAN or DONE
// ---------------------------------------------------------------------------
module tag_search_ctrl
   import tag_search_ctrl_pkg::*;
#(
   parameter int W  = TS_W,
   parameter int N  = TS_N,
   parameter int IW = TS_IW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_idx,
   input  logic [W-1:0]  wr_tag,
   input  logic          wr_vld,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [W-1:0]  req_key,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_hit,
   output logic [IW-1:0] rsp_idx,
   output logic          busy
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   // Tag store
   logic [W-1:0]  r_tag [N];
   logic          r_vld [N];

   // Control and result registers
   ts_state_t     r_state;
   logic [IW-1:0] r_ptr;
   logic [W-1:0]  r_key;
   logic          r_req_ready;
   logic          r_rsp_valid;
   logic          r_rsp_hit;
   logic [IW-1:0] r_rsp_idx;
   logic          r_busy;

   logic [W-1:0]  w_cur_tag;
   logic          w_cur_vld;
   logic          w_equ;
   logic          w_match;

   // The entry under the pointer is read from the registered store, so a
   // write landing on the same edge is only visible on the following cycle.
   assign w_cur_tag = r_tag[r_ptr];
   assign w_cur_vld = r_vld[r_ptr];

   tag_eq6 u_eq (
      .a   (w_cur_tag),
      .b   (r_key),
      .equ (w_equ)
   );

   assign w_match = w_equ && w_cur_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            r_tag[i] <= '0;
            r_vld[i] <= 1'b0;
         end
      end else if (wr_en) begin
         r_tag[wr_idx] <= wr_tag;
         r_vld[wr_idx] <= wr_vld;
      end
   end

   // FSM with registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_key       <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_hit   <= 1'b0;
         r_rsp_idx   <= '0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_key       <= req_key;
                  r_ptr       <= '0;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= S_SCAN;
               end
            end

            S_SCAN: begin
               if (w_match) begin
                  r_rsp_hit   <= 1'b1;
                  r_rsp_idx   <= r_ptr;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (r_ptr == LAST_IDX) begin
                  r_rsp_hit   <= 1'b0;
                  r_rsp_idx   <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end

            S_DONE: begin
               // Handoff cycle returns to IDLE only; a request seen here
               // waits for the next cycle when req_ready is high again.
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_hit   <= 1'b0;
                  r_rsp_idx   <= '0;
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_rsp_valid <= 1'b0;
               r_rsp_hit   <= 1'b0;
               r_rsp_idx   <= '0;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_hit   = r_rsp_hit;
   assign rsp_idx   = r_rsp_idx;
   assign busy      = r_busy;

endmodule : tag_search_ctrl

// File: tb/tb_tag_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tag_search_ctrl
// Self-checking bench: directed scenarios plus randomized searches with
// random concurrent writes, checked against a behavioural store model.
// ---------------------------------------------------------------------------
module tb_tag_search_ctrl;

   localparam int W  = 6;
   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [W-1:0]  wr_tag;
   logic          wr_vld;
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_key;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_hit;
   logic [IW-1:0] rsp_idx;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model of the tag store as it stands after each clock edge
   logic [W-1:0] m_tag [N];
   logic         m_vld [N];

   tag_search_ctrl #(.W(W), .N(N), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_tag    (wr_tag),
      .wr_vld    (wr_vld),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_key   (req_key),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_hit   (rsp_hit),
      .rsp_idx   (rsp_idx),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_tag[i] = '0;
         m_vld[i] = 1'b0;
      end
   endtask

   // One clock edge; the model follows what the edge does to the store.
   task automatic step();
      @(posedge clk);
      if (rst) model_clear();
      else if (wr_en) begin
         m_tag[wr_idx] = wr_tag;
         m_vld[wr_idx] = wr_vld;
      end
      #1;
   endtask

   task automatic write(input int idx, input logic [W-1:0] tag, input logic v);
      wr_en = 1'b1; wr_idx = IW'(idx); wr_tag = tag; wr_vld = v;
      step();
      wr_en = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, req_ready, 1);
      chk({tag, "_valid"}, rsp_valid, 0);
      chk({tag, "_hit"},   rsp_hit,   0);
      chk({tag, "_idx"},   rsp_idx,   0);
      chk({tag, "_busy"},  busy,      0);
   endtask

   // Search for key. Entry k is examined on the store as it stands after
   // accept edge + k; the result appears one edge after the first match,
   // or after accept + N on a miss.
   //   dir_k  : scan step during which a directed write is driven (-1 none)
   //   rnd_wr : also drive random writes during the scan
   //   hold   : cycles rsp_ready is held low in DONE
   //   rst_k  : scan step at which reset is asserted (-1 none)
   task automatic search(input logic [W-1:0] key, input int dir_k,
                         input int dir_idx, input logic [W-1:0] dir_tag,
                         input logic dir_vld, input bit rnd_wr,
                         input int hold, input int rst_k);
      bit            found;
      int            exp_k;
      logic [IW-1:0] exp_idx;
      chk("pre_ready", req_ready, 1);
      req_valid = 1'b1;
      req_key   = key;
      step();
      req_valid = 1'b0;
      req_key   = W'($urandom);
      found = 1'b0;
      exp_k = 0;
      for (int k = 0; k < N; k++) begin
         if (m_vld[k] && m_tag[k] == key) begin
            found = 1'b1;
            exp_k = k;
         end
         if (k == rst_k) begin
            rst = 1'b1;
            #1;
            model_clear();
            chk_idle("rst_async");
            step();
            step();
            rst = 1'b0;
            step();
            chk_idle("rst_after");
            return;
         end
         chk("scan_valid", rsp_valid, 0);
         chk("scan_ready", req_ready, 0);
         chk("scan_busy",  busy,      1);
         if (k == dir_k) begin
            wr_en = 1'b1; wr_idx = IW'(dir_idx); wr_tag = dir_tag; wr_vld = dir_vld;
         end else if (rnd_wr && $urandom_range(0, 2) == 0) begin
            wr_en  = 1'b1;
            wr_idx = IW'($urandom_range(0, N - 1));
            wr_tag = W'($urandom_range(0, 7));
            wr_vld = 1'($urandom_range(0, 1));
         end
         step();
         wr_en = 1'b0;
         if (found) break;
      end
      exp_idx = found ? IW'(exp_k) : '0;
      for (int h = 0; h <= hold; h++) begin
         chk("done_valid", rsp_valid, 1);
         chk("done_hit",   rsp_hit,   {31'd0, found});
         chk("done_idx",   rsp_idx,   {29'd0, exp_idx});
         chk("done_ready", req_ready, 0);
         chk("done_busy",  busy,      1);
         rsp_ready = (h == hold);
         // A request offered during the handoff cycle must not be taken.
         if (h == hold) req_valid = 1'($urandom_range(0, 1));
         step();
      end
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      chk_idle("handoff");
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_tag = '0; wr_vld = 1'b0;
      req_valid = 1'b0; req_key = '0; rsp_ready = 1'b0;
      model_clear();
      #1;
      chk_idle("reset");
      step();
      step();
      rst = 1'b0;
      chk_idle("post_reset");

      // Empty store: miss with full-scan latency
      search(6'h2A, -1, 0, '0, 1'b0, 1'b0, 0, -1);

      // Hit at entry 0
      write(0, 6'h2A, 1'b1);
      search(6'h2A, -1, 0, '0, 1'b0, 1'b0, 0, -1);

      // Duplicates and valid gating
      write(3, 6'h15, 1'b1);
      write(6, 6'h15, 1'b1);
      write(1, 6'h15, 1'b0);
      search(6'h15, -1, 0, '0, 1'b0, 1'b0, 0, -1);

      // Miss with backpressure
      search(6'h3F, -1, 0, '0, 1'b0, 1'b0, 4, -1);

      // Write behind the pointer is ignored; ahead of it is seen
      search(6'h07, 2, 1, 6'h07, 1'b1, 1'b0, 0, -1);
      write(1, 6'h07, 1'b0);
      search(6'h07, 2, 5, 6'h07, 1'b1, 1'b0, 1, -1);

      // Write to the entry being compared this cycle is not seen
      write(5, 6'h00, 1'b0);
      search(6'h09, 4, 4, 6'h09, 1'b1, 1'b0, 0, -1);

      // Reset mid-scan, then the cleared store misses
      search(6'h3F, -1, 0, '0, 1'b0, 1'b0, 0, 4);
      search(6'h2A, -1, 0, '0, 1'b0, 1'b0, 0, -1);

      // Randomized searches over a small tag space with concurrent writes
      for (int it = 0; it < 60; it++) begin
         int nw;
         nw = $urandom_range(0, 3);
         for (int j = 0; j < nw; j++)
            write($urandom_range(0, N - 1), W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         search(W'($urandom_range(0, 7)), -1, 0, '0, 1'b0, 1'b1,
                $urandom_range(0, 3), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time limit so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule : tb_tag_search_ctrl
